// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte/state types and the
// three-state handshake FSM encoding used by the iterative round engines.
package aes_pkg;

  localparam int AES_N = 4;

  typedef logic [7:0] byte_t;

  // Indexed [row][column]; each element is one state byte.
  typedef byte_t [AES_N-1:0][AES_N-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_e;

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Valid/ready handshake bundle for the InvSubBytes engine: an input state
// channel and an output result channel.
interface inv_sub_bytes_iter_if #(
  parameter int N = aes_pkg::AES_N
);

  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0][N-1:0][7:0] state_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0][N-1:0][7:0] state_out;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup; counterpart of sbox, shared by the
// decryption blocks.
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t byte_in,
  output byte_t byte_out
);

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_out = INV_SBOX[byte_in];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: one column per cycle through N inv_sbox
// instances. Define AES_INV_SUB_BYTES_PARALLEL_EN for a single-cycle N*N build.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int N = AES_N
) (
  input logic                  clk,
  input logic                  rst_n,
  inv_sub_bytes_iter_if.slave  bus
);

  fsm_e                     state;
  logic                     out_valid_q;
  logic [N-1:0][N-1:0][7:0] state_buf;
  logic [N-1:0][N-1:0][7:0] buf_sub;
  logic                     busy_last;
  logic                     accept;

  // Accepting in DONE while the result drains gives one state per N cycles.
  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_buf;

`ifdef AES_INV_SUB_BYTES_PARALLEL_EN

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      inv_sbox u_inv_sbox (
        .byte_in  (state_buf[r][c]),
        .byte_out (buf_sub[r][c])
      );
    end
  end

  assign busy_last = 1'b1;

`else

  localparam int COL_W = (N > 1) ? $clog2(N) : 1;

  logic [COL_W-1:0] col;
  logic [N-1:0][7:0] sub_col;

  for (genvar r = 0; r < N; r++) begin : g_row
    inv_sbox u_inv_sbox (
      .byte_in  (state_buf[r][col]),
      .byte_out (sub_col[r])
    );
  end

  // NOTE: default the whole buffer first so only the active column changes
  // and no latch is inferred for the untouched bytes.
  always_comb begin
    buf_sub = state_buf;
    for (int r = 0; r < N; r++) begin
      buf_sub[r][col] = sub_col[r];
    end
  end

  assign busy_last = (col == COL_W'(N - 1));

`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; the later accept branch overrides the DONE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      // NOTE: the buffer is deliberately reset because state_out exposes it
      // directly and must read all zeros after reset.
      state_buf   <= '0;
`ifndef AES_INV_SUB_BYTES_PARALLEL_EN
      col         <= '0;
`endif
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          state_buf <= buf_sub;
          if (busy_last) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
`ifndef AES_INV_SUB_BYTES_PARALLEL_EN
          else begin
            col <= col + 1'b1;
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        state     <= BUSY;
        state_buf <= bus.state_in;
`ifndef AES_INV_SUB_BYTES_PARALLEL_EN
        col       <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed self-checking bench for inv_sub_bytes_iter; expected latency follows
// AES_INV_SUB_BYTES_PARALLEL_EN.
module tb_inv_sub_bytes_iter;
  import aes_pkg::*;

  localparam int N = AES_N;
`ifdef AES_INV_SUB_BYTES_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = N;
`endif

  typedef logic [N-1:0][N-1:0][7:0] st_t;
  localparam int SW = $bits(st_t);

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  inv_sub_bytes_iter_if #(.N(N)) bus ();

  inv_sub_bytes_iter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the acceptance edge until out_valid, bounded.
  task automatic wait_out(input string tag);
    int cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    check(tag, SW'(cyc), SW'(LAT));
  endtask

  function automatic st_t fill_cols(input logic [7:0] c0, c1, c2, c3);
    st_t s;
    for (int r = 0; r < N; r++) begin
      s[r][0] = c0; s[r][1] = c1; s[r][2] = c2; s[r][3] = c3;
    end
    return s;
  endfunction

  function automatic st_t fill_rows(input logic [7:0] r0, r1, r2, r3);
    st_t s;
    for (int c = 0; c < N; c++) begin
      s[0][c] = r0; s[1][c] = r1; s[2][c] = r2; s[3][c] = r3;
    end
    return s;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    st_t s2, e2, hold;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.state_in  = '0;
    step();
    step();
    check("rst_in_ready",  SW'(bus.in_ready),  SW'(1));
    check("rst_out_valid", SW'(bus.out_valid), SW'(0));
    check("rst_state_out", bus.state_out, '0);
    rst_n = 1'b1;

    // All 0x63 -> all 0x00
    bus.state_in  = fill_cols(8'h63, 8'h63, 8'h63, 8'h63);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t1_busy_in_ready",  SW'(bus.in_ready),  SW'(0));
    check("t1_busy_out_valid", SW'(bus.out_valid), SW'(0));
    wait_out("t1_latency");
    check("t1_result", bus.state_out, '0);
    check("t1_done_in_ready", SW'(bus.in_ready), SW'(1));
    step();
    check("t1_out_valid_low", SW'(bus.out_valid), SW'(0));
    check("t1_in_ready_idle", SW'(bus.in_ready),  SW'(1));

    // Row0 = 63 7c 16 ed, rest 00; held under backpressure
    s2 = '0;
    s2[0][0] = 8'h63; s2[0][1] = 8'h7c; s2[0][2] = 8'h16; s2[0][3] = 8'hed;
    e2 = fill_cols(8'h52, 8'h52, 8'h52, 8'h52);
    e2[0][0] = 8'h00; e2[0][1] = 8'h01; e2[0][2] = 8'hff; e2[0][3] = 8'h53;
    bus.out_ready = 1'b0;
    bus.state_in  = s2;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out("t2_latency");
    check("t2_result", bus.state_out, e2);
    hold = fill_rows(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 10; i++) begin
      bus.state_in = hold;
      bus.in_valid = 1'b1;
      step();
      check("bp_state_out", bus.state_out, e2);
      check("bp_out_valid", SW'(bus.out_valid), SW'(1));
      check("bp_in_ready",  SW'(bus.in_ready),  SW'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", SW'(bus.in_ready), SW'(1));
    step();
    check("bp_consumed", SW'(bus.out_valid), SW'(0));

    // Back-to-back: column pattern then row pattern
    bus.state_in = fill_cols(8'h00, 8'h52, 8'h09, 8'h6a);
    bus.in_valid = 1'b1;
    step();
    bus.state_in = fill_rows(8'h63, 8'h7c, 8'h16, 8'hed);
    wait_out("b2b_a_latency");
    check("b2b_a_result", bus.state_out, fill_cols(8'h52, 8'h48, 8'h40, 8'h58));
    check("b2b_a_in_ready", SW'(bus.in_ready), SW'(1));
    step();
    bus.in_valid = 1'b0;
    check("b2b_b_accepted", SW'(bus.out_valid), SW'(0));
    wait_out("b2b_b_latency");
    check("b2b_b_result", bus.state_out, fill_rows(8'h00, 8'h01, 8'hff, 8'h53));
    step();
    check("b2b_b_consumed", SW'(bus.out_valid), SW'(0));

    // Reset pulse at col=2, then a fresh state
    bus.state_in = fill_cols(8'hed, 8'hed, 8'hed, 8'hed);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", SW'(bus.out_valid), SW'(0));
    check("mid_rst_in_ready",  SW'(bus.in_ready),  SW'(1));
    check("mid_rst_state_out", bus.state_out, '0);
    #2;
    rst_n = 1'b1;
    bus.state_in = fill_cols(8'h6a, 8'h09, 8'h52, 8'h00);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out("post_rst_latency");
    check("post_rst_result", bus.state_out, fill_cols(8'h58, 8'h40, 8'h48, 8'h52));
    step();
    check("post_rst_consumed", SW'(bus.out_valid), SW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
